// File: rtl/int8_array_pkg.sv
// Shared definitions for the int8 PE array blocks.
//   wl_state_t : weight-loader FSM states.
//   chk_width  : width of a signed sum of `rows` values of `input_bits` each,
//                wide enough that the sum never overflows.
package int8_array_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush,
    StDone
  } wl_state_t;

  function automatic int unsigned chk_width(input int unsigned input_bits,
                                            input int unsigned rows);
    return input_bits + $clog2(rows);
  endfunction

endpackage

// File: rtl/int8_weight_loader_if.sv
// Bus between the array controller (master) and the weight loader (slave).
//   start             : one-cycle load request
//   w_data/w_valid/
//   w_ready           : valid/ready weight stream
//   e/e_enable        : weight-load chain at the column top
//   busy/done         : load status
//   chk/chk_valid     : ABFT checksum, present only with WEIGHT_LOADER_CHECKSUM_EN
interface int8_weight_loader_if #(
  parameter int unsigned inputBits = 8,
  parameter int unsigned ROWS      = 8
) ();

  logic                 start;
  logic [inputBits-1:0] w_data;
  logic                 w_valid;
  logic                 w_ready;
  logic [inputBits-1:0] e;
  logic                 e_enable;
  logic                 busy;
  logic                 done;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam int unsigned ChkW = int8_array_pkg::chk_width(inputBits, ROWS);
  logic [ChkW-1:0]      chk;
  logic                 chk_valid;
`endif

  modport master (
    output start, w_data, w_valid,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    input  chk, chk_valid,
`endif
    input  w_ready, e, e_enable, busy, done
  );

  modport slave (
    input  start, w_data, w_valid,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output chk, chk_valid,
`endif
    output w_ready, e, e_enable, busy, done
  );

endinterface

// File: rtl/int8_weight_loader.sv
// Writer for one PE column's stationary-weight chain. Accepts ROWS int8 weights
// on a valid/ready stream, shifts them down the column via e/e_enable, then
// freezes the chain and pulses done. The first accepted beat ends in the
// deepest row (ROWS-1), the last in row 0.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : int8_weight_loader_if slave (start, w_*, e, e_enable, busy, done,
//              and chk/chk_valid when WEIGHT_LOADER_CHECKSUM_EN is defined)
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to add a signed sum of
// the loaded weights, reported on chk with chk_valid coincident with done.
module int8_weight_loader
  import int8_array_pkg::*;
#(
  parameter int unsigned inputBits = 8,
  parameter int unsigned ROWS      = 8
) (
  input logic                  clk,
  input logic                  rst,
  int8_weight_loader_if.slave  bus
);

  localparam int unsigned           CntW     = $clog2(ROWS);
  localparam logic [CntW-1:0]       LastBeat = CntW'(ROWS - 1);

  wl_state_t            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [inputBits-1:0] e_q, e_d;
  logic                 e_enable_q, e_enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 w_ready;
  logic                 accept;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam int unsigned ChkW = chk_width(inputBits, ROWS);
  logic [ChkW-1:0]      acc_q, acc_d;
  logic                 chk_valid_q, chk_valid_d;
`endif

  assign w_ready = (state_q == StLoad);
  assign accept  = bus.w_valid & w_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StLoad;
      StLoad:  if (accept && (cnt_q == LastBeat)) state_d = StFlush;
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d      = cnt_q;
    e_d        = e_q;
    // Any cycle without an accepted beat freezes the whole column, including
    // the FLUSH->DONE edge once the final shift has happened.
    e_enable_d = accept;
    busy_d     = busy_q;
    done_d     = (state_q == StFlush);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    acc_d       = acc_q;
    chk_valid_d = (state_q == StFlush);
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          busy_d = 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          acc_d  = '0;
`endif
        end
      end
      StLoad: begin
        if (accept) begin
          e_d   = bus.w_data;
          cnt_d = (cnt_q == LastBeat) ? '0 : cnt_q + 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          acc_d = acc_q + {{(ChkW - inputBits){bus.w_data[inputBits-1]}}, bus.w_data};
`endif
        end
      end
      StFlush: ;
      StDone:  busy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      e_q        <= '0;
      e_enable_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      e_q        <= e_d;
      e_enable_q <= e_enable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      chk_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      chk_valid_q <= chk_valid_d;
    end
  end

  // The last add lands on the edge into FLUSH, so chk is already final in DONE.
  assign bus.chk       = acc_q;
  assign bus.chk_valid = chk_valid_q;
`endif

  assign bus.w_ready  = w_ready;
  assign bus.e        = e_q;
  assign bus.e_enable = e_enable_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_int8_weight_loader.sv
module tb_int8_weight_loader;

  localparam int unsigned InBits = 8;
  localparam int unsigned Rows   = 4;

  typedef struct packed {
    logic [31:0]            done_cyc;
    logic [31:0]            sum;
    logic [Rows-1:0][7:0]   rows;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_miss;
  int   n_push;
  int   done_cnt;
  int   en_cnt;
  int   last_done;
  int   prev_done;
  exp_t sb[$];
  logic [7:0] chain [Rows];

  int8_weight_loader_if #(.inputBits(InBits), .ROWS(Rows)) bus ();

  int8_weight_loader #(
    .inputBits(InBits),
    .ROWS     (Rows)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the column's PE weight registers.
  always @(posedge clk) begin
    if (bus.e_enable) begin
      chain[0] <= bus.e;
      for (int r = 1; r < Rows; r++) chain[r] <= chain[r-1];
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: compares everything observable at each done pulse.
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      if (bus.start && !bus.busy) en_cnt = 0;
      if (bus.e_enable) en_cnt++;
      if (bus.done) begin
        done_cnt++;
        prev_done = last_done;
        last_done = cyc;
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          x = sb.pop_front();
          for (int r = 0; r < Rows; r++)
            check_eq($sformatf("row%0d", r), int'($signed(chain[r])), int'($signed(x.rows[r])));
          check_eq("done_cycle", cyc, int'(x.done_cyc));
          check_eq("enable_count", en_cnt, Rows);
          check_eq("busy_at_done", int'(bus.busy), 1);
          check_eq("enable_at_done", int'(bus.e_enable), 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          check_eq("chk_valid", int'(bus.chk_valid), 1);
          check_eq("chk", int'($signed(bus.chk)), int'($signed(x.sum)));
`endif
        end
      end
    end
  end

  // w[0] is the first beat. Returns in the first IDLE cycle after the load,
  // or right after the last beat when n_beats < Rows.
  task automatic load_set(input logic [Rows-1:0][7:0] w, input int n_beats,
                          input int gap_after, input int gap_len,
                          input bit spurious, input bit push);
    exp_t x;
    int   sum;
    bit   acc;
    int   tries;
    sum = 0;
    for (int i = 0; i < Rows; i++) begin
      x.rows[i] = w[Rows-1-i];
      sum += int'($signed(w[i]));
    end
    x.sum      = sum;
    x.done_cyc = cyc + Rows + 2 + gap_len;
    if (push) begin
      sb.push_back(x);
      n_push++;
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      if (gap_len > 0 && i == gap_after) begin
        bus.w_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          check_eq("gap_w_ready", int'(bus.w_ready), 1);
          if (g > 0) check_eq("gap_enable", int'(bus.e_enable), 0);
          @(posedge clk); #1;
        end
      end
      bus.w_data  = w[i];
      bus.w_valid = 1'b1;
      if (spurious && i == 1) bus.start = 1'b1;
      tries = 0;
      do begin
        @(negedge clk);
        acc = bus.w_ready;
        @(posedge clk); #1;
        bus.start = 1'b0;
        tries++;
      end while (!acc && tries < 20);
      if (!acc) check_eq("beat_timeout", 0, 1);
    end
    bus.w_valid = 1'b0;
    if (n_beats == Rows) begin
      if (spurious) begin
        @(posedge clk); #1;
        bus.start = 1'b1;   // lands in the DONE cycle
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("ignored_start_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("ignored_start_w_ready", int'(bus.w_ready), 0);
        @(posedge clk); #1;
      end else begin
        repeat (2) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    n_vec = 0; n_miss = 0; n_push = 0; done_cnt = 0; en_cnt = 0;
    last_done = 0; prev_done = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.w_valid = 1'b0; bus.w_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_e", int'(bus.e), 0);
    check_eq("rst_e_enable", int'(bus.e_enable), 0);
    check_eq("rst_w_ready", int'(bus.w_ready), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain load, w_valid held high
    load_set({8'd4, 8'd3, 8'd2, 8'd1}, Rows, 0, 0, 1'b0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end

    // Same weights, 3-cycle w_valid gap after beat 2
    load_set({8'd4, 8'd3, 8'd2, 8'd1}, Rows, 2, 3, 1'b0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end

    // start during LOAD and during DONE is ignored
    d0 = done_cnt;
    load_set({8'd8, 8'd7, 8'd6, 8'd5}, Rows, 0, 0, 1'b1, 1'b1);
    check_eq("single_done_pulse", done_cnt - d0, 1);
    repeat (2) begin @(posedge clk); #1; end

    // Reset after beat 2, then a full fresh load
    load_set({8'h2c, 8'h2b, 8'h2a, 8'h29}, 2, 0, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_e", int'(bus.e), 0);
    check_eq("mid_rst_e_enable", int'(bus.e_enable), 0);
    check_eq("mid_rst_w_ready", int'(bus.w_ready), 0);
    check_eq("mid_rst_busy", int'(bus.busy), 0);
    check_eq("mid_rst_done", int'(bus.done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    load_set({8'h13, 8'h12, 8'h11, 8'h10}, Rows, 0, 0, 1'b0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end

    // Checksum patterns: -128,127,-1,5 and all -128
    load_set({8'd5, 8'hff, 8'd127, 8'h80}, Rows, 0, 0, 1'b0, 1'b1);
    load_set({8'h80, 8'h80, 8'h80, 8'h80}, Rows, 0, 0, 1'b0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end

    // Back-to-back loads, second start in the first IDLE cycle
    load_set({8'hf1, 8'hf2, 8'hf3, 8'hf4}, Rows, 0, 0, 1'b0, 1'b1);
    load_set({8'd9, 8'hf7, 8'd33, 8'h81}, Rows, 0, 0, 1'b0, 1'b1);
    check_eq("b2b_period", last_done - prev_done, Rows + 3);

    repeat (3) begin @(posedge clk); #1; end
    check_eq("sb_drained", sb.size(), 0);
    check_eq("done_total", done_cnt, n_push);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/int8_weight_loader.md
# int8_weight_loader

Drives the weight-load chain (`e`, `e_enable`) at the top of one int8 PE column. It accepts a valid/ready stream of int8 weights, shifts exactly `ROWS` of them down the column's enabled weight registers, and then freezes the chain. It signals completion to the array controller and can optionally report an ABFT checksum of the loaded weights. It is the writer for the column's stationary-weight registers: the PEs hold whatever is in their `e` register while `e_enable` is low.

## Interface
- `inputBits`, 8, weight width; matches the PE `inputBits`.
- `ROWS`, 8, number of PEs in the column, which is the depth of the `e` chain; must be ≥ 2.
- `clk`  in  1  single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to load a new weight set; sampled only in IDLE.
- `w_data`  in  inputBits  weight beat, signed int8.
- `w_valid`  in  1  `w_data` is valid.
- `w_ready`  out  1  loader accepts a beat this cycle.
- `e`  out  inputBits  to the column-top PE `e` input.
- `e_enable`  out  1  shift enable, shared by every PE in the column.
- `busy`  out  1  high from start acceptance until `done`, inclusive.
- `done`  out  1  one-cycle pulse: all `ROWS` weights are in place.
- `chk`  out  inputBits+$clog2(ROWS)  signed sum of the loaded weights (only with the macro).
- `chk_valid`  out  1  coincident with `done` (only with the macro).

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE → LOAD on `start`. `start` in any other state is ignored.
- LOAD:
  - `w_ready` = 1 (combinational from state).
  - A beat is accepted when `w_valid & w_ready`.
  - On acceptance: `e` ← `w_data` and `e_enable` ← 1, both registered.
  - On a non-acceptance cycle: `e_enable` ← 0, so the whole column freezes; `e` holds.
  - Beat counter 0..ROWS-1. Acceptance of beat ROWS-1 → FLUSH, counter cleared.
- FLUSH: `w_ready` = 0. `e_enable` is still high from the last beat, which performs the final shift. → DONE.
- DONE: `e_enable` = 0, `done` = 1, `busy` = 1. → IDLE.
- Ordering: the first accepted beat ends in row ROWS-1 (deepest PE); the last accepted beat ends in row 0.
- A `w_valid` gap of any length mid-load is legal. It only stretches LOAD; the chain holds state during the gap.
- Reset, including mid-load:
  - State → IDLE.
  - `e` = 0, `e_enable` = 0, `w_ready` = 0, `busy` = 0, `done` = 0, counter = 0.
  - With the macro: `chk` = 0, `chk_valid` = 0.
  - A partially shifted column is left as-is; the controller must reload.
- Outputs `e`, `e_enable`, `busy`, `done` are registered.

## Timing
- `start` sampled at cycle 0; LOAD from cycle 1, with `w_ready` high in cycle 1.
- With `w_valid` held high:
  - Beats accepted in cycles 1..ROWS.
  - `e_enable` high in cycles 2..ROWS+1.
  - FLUSH in cycle ROWS+1.
  - `done` in cycle ROWS+2.
  - IDLE in cycle ROWS+3; a new `start` is accepted in that cycle.
- Minimum load period: ROWS+3 cycles.
- `busy` covers cycles 1..ROWS+2.

## Configuration
- `WEIGHT_LOADER_CHECKSUM_EN` defined:
  - Sign-extended accumulator, cleared on start acceptance, adds each accepted beat.
  - `chk` is stable and `chk_valid` = 1 during the DONE cycle.
  - `chk` holds its value until the next start.
  - Sum width is inputBits+$clog2(ROWS), so the sum never overflows.
- Undefined: the `chk`/`chk_valid` ports and the accumulator are absent.

## Structure
- Shared package `int8_array_pkg`:
  - State enum `wl_state_t` (IDLE, LOAD, FLUSH, DONE).
  - Function `chk_width(inputBits, ROWS)`.
- No sub-module. The FSM, counter and accumulator are flat in `int8_weight_loader`.

## Test plan
- ROWS=4, `start`, weights 1,2,3,4 with `w_valid` always high → `e_enable` high for exactly 4 cycles; a 4-deep model chain holds rows0..3 = 4,3,2,1; `done` pulses in cycle 6.
- ROWS=4, `w_valid` low for 3 cycles after beat 2 → `e_enable` low during the gap; final chain contents unchanged vs. the no-gap run; `done` delayed by 3 cycles.
- `start` asserted during LOAD and during DONE → ignored; exactly 4 beats consumed; one `done` pulse.
- `rst` asserted after beat 2 → all outputs 0 asynchronously; IDLE; the next `start` loads a full 4 fresh beats.
- With `WEIGHT_LOADER_CHECKSUM_EN`, weights -128, 127, -1, 5 → `chk` = 3 with `chk_valid` coincident with `done`; all -128 → `chk` = -512 with no overflow.
- Back-to-back loads with `start` in the first IDLE cycle → period is exactly ROWS+3 cycles; the second set fully replaces the first.
